// File: rtl/mbuf_pkg.sv
// Shared helpers for the mbuf elastic buffer chain: occupancy sizing and inversion parity.
package mbuf_pkg;

   localparam int MAX_DEPTH = 32;

   function automatic int clog2_ceil(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Occupancy must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return (clog2_ceil(depth + 1) < 1) ? 1 : clog2_ceil(depth + 1);
   endfunction

   // Odd number of inverting stages means the output is the complement of the input.
   function automatic logic inv_parity(input logic [MAX_DEPTH-1:0] mask);
      return ^mask;
   endfunction

endpackage

// File: rtl/mbuf_stage.sv
// One valid/data register slice of the buffer chain; stores up_data, optionally inverted.
// Latency 1 cycle; accepts whenever empty or when the downstream slice takes the held word.
module mbuf_stage #(
   parameter int   WIDTH = 8,
   parameter logic INV   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic ready;
   logic take;

   assign ready = !valid || dn_ready;
   assign take  = up_valid && ready && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (flush) valid <= 1'b0;
         else       valid <= take || (valid && !dn_ready);
         // Data only moves on accept so a stalled slice stays bit-stable.
         if (take) data <= up_data ^ {WIDTH{INV}};
      end
   end

endmodule

// File: rtl/mbuf_pipe.sv
// Elastic chain of DEPTH register slices with valid/ready, flush and occupancy count.
// Latency DEPTH cycles; bubbles collapse, in_ready drops only when full and out_ready is low.
module mbuf_pipe
   import mbuf_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 2,
   parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}}
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OW = occ_width(DEPTH);

   logic [DEPTH-1:0]            vld;
   logic [DEPTH:0]              rdy;
   logic [DEPTH-1:0][WIDTH-1:0] dat;
   logic                        in_acc;
   logic                        out_acc;

   // Ready ripples back from the consumer; built from registered valids so no loop exists.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy[i] = !vld[i] || rdy[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_v;
      logic [WIDTH-1:0] up_d;

      if (i == 0) begin : g_head
         assign up_v = in_valid && !reset;
         assign up_d = in_data;
      end else begin : g_body
         assign up_v = vld[i-1];
         assign up_d = dat[i-1];
      end

      mbuf_stage #(
         .WIDTH (WIDTH),
         .INV   (INV_MASK[i])
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .up_valid (up_v),
         .up_data  (up_d),
         .dn_ready (rdy[i+1]),
         .valid    (vld[i]),
         .data     (dat[i])
      );
   end

   assign in_ready  = rdy[0] && !flush && !reset;
   assign out_valid = vld[DEPTH-1] && !reset;
   assign out_data  = dat[DEPTH-1];

   assign in_acc  = in_valid && in_ready;
   assign out_acc = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset || flush) occupancy <= '0;
      else                occupancy <= occupancy + OW'(in_acc) - OW'(out_acc);
   end

endmodule

// File: tb/tb_mbuf_pipe.sv
// Scoreboard bench for mbuf_pipe: directed reset/latency/stream/backpressure/flush cases then random traffic.
module tb_mbuf_pipe;

   localparam int               WIDTH    = 8;
   localparam int               DEPTH    = 3;
   localparam logic [DEPTH-1:0] INV_MASK = 3'b001;
   localparam int               OW       = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [OW-1:0]    occupancy;

   int               vectors     = 0;
   int               miscompares = 0;
   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] mon_exp;
   logic             chk_en = 1'b0;

   mbuf_pipe #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .INV_MASK (INV_MASK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // An odd count of inverting stages complements the word end to end.
   function automatic logic [WIDTH-1:0] expect_of(input logic [WIDTH-1:0] d);
      return ($countones(INV_MASK) % 2 == 1) ? ~d : d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then record whether the word is accepted.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic fl, input logic rst, output logic acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      #3;
      acc = in_valid && in_ready;
      if (acc) sb_q.push_back(expect_of(in_data));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (chk_en) check("occupancy", 32'(occupancy), 32'(sb_q.size()));
         #2;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("output_while_model_empty", 32'(out_valid), 32'(0));
            end else begin
               mon_exp = sb_q.pop_front();
               check("out_data", 32'(out_data), 32'(mon_exp));
            end
         end
         if (flush || reset) sb_q.delete();
      end
   end

   initial begin
      logic acc;
      int   lat, nacc, cnt, first, last, ncyc, rst_at;

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      out_ready = 1'b0;

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, acc);
         check("reset_in_ready", 32'(in_ready), 32'(0));
      end
      check("reset_out_valid", 32'(out_valid), 32'(0));
      check("reset_occupancy", 32'(occupancy), 32'(0));
      check("reset_out_data", 32'(out_data), 32'(0));
      chk_en = 1'b1;

      // Single word into an empty pipe.
      step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, acc);
      check("latency_accept", 32'(acc), 32'(1));
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
         if (out_valid) begin
            lat = k;
            check("latency_data", 32'(out_data), 32'(8'h5A));
         end
      end
      check("latency_cycles", 32'(lat), 32'(DEPTH));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

      // Back-to-back stream.
      nacc = 0; cnt = 0; first = -1; last = -1;
      for (int j = 0; j < 16 + DEPTH + 3; j++) begin
         step(j < 16, 8'(j), 1'b1, 1'b0, 1'b0, acc);
         nacc += int'(acc);
         if (out_valid) begin
            cnt++;
            if (first < 0) first = j;
            last = j;
         end
      end
      check("stream_accepts", 32'(nacc), 32'(16));
      check("stream_words", 32'(cnt), 32'(16));
      check("stream_first_out", 32'(first), 32'(DEPTH));
      check("stream_no_gaps", 32'(last - first), 32'(15));

      // Backpressure fill, full stall, then pass-through when full.
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, acc);
      check("bp_acc_11", 32'(acc), 32'(1));
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
      check("bp_acc_22", 32'(acc), 32'(1));
      check("bp_occ_1", 32'(occupancy), 32'(1));
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, acc);
      check("bp_acc_33", 32'(acc), 32'(1));
      check("bp_occ_2", 32'(occupancy), 32'(2));
      step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, acc);
      check("bp_full_reject", 32'(acc), 32'(0));
      check("bp_occ_full", 32'(occupancy), 32'(DEPTH));
      check("bp_head_data", 32'(out_data), 32'(8'hEE));
      step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, acc);
      check("bp_still_reject", 32'(acc), 32'(0));
      check("bp_stable_data", 32'(out_data), 32'(8'hEE));
      check("bp_stable_valid", 32'(out_valid), 32'(1));
      step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, acc);
      check("bp_pass_through", 32'(acc), 32'(1));
      for (int j = 0; j < DEPTH + 3; j++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

      // Flush with a word being delivered in the same cycle.
      step(1'b1, 8'h60, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 8'h62, 1'b1, 1'b1, 1'b0, acc);
      check("flush_no_accept", 32'(acc), 32'(0));
      check("flush_out_valid", 32'(out_valid), 32'(1));
      check("flush_occ_before", 32'(occupancy), 32'(2));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      check("flush_occ_after", 32'(occupancy), 32'(0));
      check("flush_valid_after", 32'(out_valid), 32'(0));

      // Random traffic with occasional flush and one mid-stream reset.
      rst_at = int'($urandom_range(2000, 8000));
      ncyc = 0; nacc = 0;
      while (nacc < 10000 && ncyc < 60000) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 63) == 0), (ncyc == rst_at || ncyc == rst_at + 1), acc);
         nacc += int'(acc);
         ncyc++;
      end
      check("random_words_reached", 32'(nacc >= 10000), 32'(1));

      for (int j = 0; j < DEPTH + 5; j++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
      check("drain_model_empty", 32'(sb_q.size()), 32'(0));
      check("drain_out_valid", 32'(out_valid), 32'(0));
      check("drain_occupancy", 32'(occupancy), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
